mimc_feistel_cipher: RTL and testbench

Multi-round MiMC-2n/n Feistel permutation engine over the BN254 scalar field. Sequences a single instance of `mimc_feistel_cipher_round` through a runtime-selectable number of rounds, fetching one round constant per round from an external constant ROM. Accepts one (left, right, key) job at a time over a valid/ready handshake and returns the permuted pair. Sits between the MiMC sponge/hash controller and the round datapath.

---
 rtl/mimc_feistel_cipher_if.sv | 28 ++
 rtl/mimc_feistel_cipher.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_mimc_feistel_cipher.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mimc_feistel_cipher_if.sv
// Job/result handshake bundle between the MiMC sponge controller (master)
// and the Feistel cipher engine (slave).
interface mimc_feistel_cipher_if #(
  parameter int N_BITS = 254,
  parameter int RW     = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_left;
  logic [N_BITS-1:0] in_right;
  logic [N_BITS-1:0] key;
  logic [RW-1:0]     cfg_rounds;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_left;
  logic [N_BITS-1:0] out_right;
  logic              busy;

  modport master (
    output in_valid, in_left, in_right, key, cfg_rounds, out_ready,
    input  in_ready, out_valid, out_left, out_right, busy
  );

  modport slave (
    input  in_valid, in_left, in_right, key, cfg_rounds, out_ready,
    output in_ready, out_valid, out_left, out_right, busy
  );
endinterface

// File: rtl/mimc_feistel_cipher.sv
// MiMC-2n/n Feistel permutation over the BN254 scalar field.
// mimc_feistel_cipher_round computes one round (t = L+key+c, t^5, add into R)
// with an iterative shift-and-add modular multiplier; mimc_feistel_cipher
// sequences it through R rounds, fetching one constant per round from ROM.

module mimc_feistel_cipher_round #(
  parameter int N_BITS             = 254,
  parameter     GALOIS_MULT_METHOD = "peasant"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BITS-1:0] left,
  input  logic [N_BITS-1:0] right,
  input  logic [N_BITS-1:0] key,
  input  logic [N_BITS-1:0] rc,
  input  logic              is_last_round,
  output logic              done,
  output logic [N_BITS-1:0] out_left,
  output logic [N_BITS-1:0] out_right
);
  // BN254 scalar field modulus, one bit wider so sums never overflow.
  localparam logic [N_BITS:0] P =
    (N_BITS+1)'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001);

  // Peasant multiplication retires four multiplier bits per cycle; any
  // other method name falls back to one bit per cycle.
  localparam int STEPS = (GALOIS_MULT_METHOD == "peasant") ? 4 : 1;

  typedef enum logic [1:0] {C_IDLE, C_MUL, C_DONE} core_state_t;

  // Operands are always reduced, so a single conditional subtract suffices.
  function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P) s = s - P;
    return s[N_BITS-1:0];
  endfunction

  core_state_t       cstate_reg, cstate_next;
  logic [1:0]        step_reg, step_next;
  logic [N_BITS-1:0] a_reg, a_next;
  logic [N_BITS-1:0] b_reg, b_next;
  logic [N_BITS-1:0] acc_reg, acc_next;
  logic [N_BITS-1:0] t_reg, t_next;
  logic [N_BITS-1:0] out_left_reg, out_left_next;
  logic [N_BITS-1:0] out_right_reg, out_right_next;

  logic [N_BITS-1:0] t_comb;
  logic [N_BITS-1:0] sum_comb;
  logic [N_BITS-1:0] chain_a, chain_b, chain_acc;

  assign t_comb   = add_mod(add_mod(left, key), rc);
  assign sum_comb = add_mod(right, acc_reg);

  // Unrolled peasant steps: acc += a when the low multiplier bit is set,
  // then a doubles and the multiplier shifts right.
  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_bit
      logic [N_BITS-1:0] a_in, b_in, acc_in;
      logic [N_BITS-1:0] a_out, b_out, acc_out;
      if (gi == 0) begin : g_head
        assign a_in   = a_reg;
        assign b_in   = b_reg;
        assign acc_in = acc_reg;
      end else begin : g_link
        assign a_in   = g_bit[gi-1].a_out;
        assign b_in   = g_bit[gi-1].b_out;
        assign acc_in = g_bit[gi-1].acc_out;
      end
      assign acc_out = b_in[0] ? add_mod(acc_in, a_in) : acc_in;
      assign a_out   = add_mod(a_in, a_in);
      assign b_out   = b_in >> 1;
    end
  endgenerate

  assign chain_a   = g_bit[STEPS-1].a_out;
  assign chain_b   = g_bit[STEPS-1].b_out;
  assign chain_acc = g_bit[STEPS-1].acc_out;

  // Next-state: t^2, then (t^2)^2, then t^4 * t, then fold into the right half.
  always_comb begin
    cstate_next    = cstate_reg;
    step_next      = step_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    acc_next       = acc_reg;
    t_next         = t_reg;
    out_left_next  = out_left_reg;
    out_right_next = out_right_reg;
    unique case (cstate_reg)
      C_IDLE: begin
        if (en) begin
          t_next      = t_comb;
          a_next      = t_comb;
          b_next      = t_comb;
          acc_next    = '0;
          step_next   = 2'd0;
          cstate_next = C_MUL;
        end
      end
      C_MUL: begin
        if (en) begin
          if (b_reg != '0) begin
            a_next   = chain_a;
            b_next   = chain_b;
            acc_next = chain_acc;
          end else begin
            unique case (step_reg)
              2'd0: begin
                a_next    = acc_reg;
                b_next    = acc_reg;
                acc_next  = '0;
                step_next = 2'd1;
              end
              2'd1: begin
                a_next    = acc_reg;
                b_next    = t_reg;
                acc_next  = '0;
                step_next = 2'd2;
              end
              default: begin
                if (is_last_round) begin
                  out_left_next  = left;
                  out_right_next = sum_comb;
                end else begin
                  out_left_next  = sum_comb;
                  out_right_next = left;
                end
                cstate_next = C_DONE;
              end
            endcase
          end
        end
      end
      default: begin
        cstate_next = C_DONE;
      end
    endcase
  end

  // Core state; cleared by the sequencer before every round.
  always_ff @(posedge clk) begin
    if (rst) begin
      cstate_reg    <= C_IDLE;
      step_reg      <= 2'd0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      t_reg         <= '0;
      out_left_reg  <= '0;
      out_right_reg <= '0;
    end else begin
      cstate_reg    <= cstate_next;
      step_reg      <= step_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      acc_reg       <= acc_next;
      t_reg         <= t_next;
      out_left_reg  <= out_left_next;
      out_right_reg <= out_right_next;
    end
  end

  assign done      = (cstate_reg == C_DONE);
  assign out_left  = out_left_reg;
  assign out_right = out_right_reg;
endmodule

module mimc_feistel_cipher #(
  parameter int N_BITS             = 254,
  parameter int N_ROUNDS           = 220,
  parameter int RW                 = $clog2(N_ROUNDS+1),
  parameter     GALOIS_MULT_METHOD = "peasant"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mimc_feistel_cipher_if.slave  bus,
  output logic [RW-1:0]         rc_addr,
  input  logic [N_BITS-1:0]     rc_data
);
  localparam logic [RW-1:0] MAX_R = RW'(N_ROUNDS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_RUN, S_NEXT, S_OUT} state_t;

  state_t            state_reg, state_next;
  logic [RW-1:0]     round_reg, round_next;
  logic [RW-1:0]     rounds_reg, rounds_next;
  logic [RW-1:0]     rc_addr_reg, rc_addr_next;
  logic [N_BITS-1:0] left_reg, left_next;
  logic [N_BITS-1:0] right_reg, right_next;
  logic [N_BITS-1:0] key_reg, key_next;
  logic [N_BITS-1:0] rc_reg, rc_next;

  logic              core_rst, core_en, core_done, is_last;
  logic [N_BITS-1:0] core_out_left, core_out_right;
  logic [RW-1:0]     clamped_rounds;

  // Zero or out-of-range round counts mean "run the full schedule".
  assign clamped_rounds = (bus.cfg_rounds == '0 || bus.cfg_rounds > MAX_R) ?
                          MAX_R : bus.cfg_rounds;
  assign is_last        = (round_reg == rounds_reg - RW'(1));

  mimc_feistel_cipher_round #(
    .N_BITS             (N_BITS),
    .GALOIS_MULT_METHOD (GALOIS_MULT_METHOD)
  ) u_round (
    .clk           (clk),
    .rst           (core_rst),
    .en            (core_en),
    .left          (left_reg),
    .right         (right_reg),
    .key           (key_reg),
    .rc            (rc_reg),
    .is_last_round (is_last),
    .done          (core_done),
    .out_left      (core_out_left),
    .out_right     (core_out_right)
  );

  // Round sequencer next-state and core control.
  always_comb begin
    state_next   = state_reg;
    round_next   = round_reg;
    rounds_next  = rounds_reg;
    rc_addr_next = rc_addr_reg;
    left_next    = left_reg;
    right_next   = right_reg;
    key_next     = key_reg;
    rc_next      = rc_reg;
    core_rst     = 1'b0;
    core_en      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
          left_next    = bus.in_left;
          right_next   = bus.in_right;
          key_next     = bus.key;
          rounds_next  = clamped_rounds;
          round_next   = '0;
          rc_addr_next = '0;
          state_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        rc_next    = rc_data;
        core_rst   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        core_en = 1'b1;
        if (core_done) begin
          left_next  = core_out_left;
          right_next = core_out_right;
          state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (is_last) begin
          state_next = S_OUT;
        end else begin
          round_next   = round_reg + RW'(1);
          rc_addr_next = round_reg + RW'(1);
          state_next   = S_FETCH;
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      round_reg   <= '0;
      rounds_reg  <= '0;
      rc_addr_reg <= '0;
      left_reg    <= '0;
      right_reg   <= '0;
      key_reg     <= '0;
      rc_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      round_reg   <= round_next;
      rounds_reg  <= rounds_next;
      rc_addr_reg <= rc_addr_next;
      left_reg    <= left_next;
      right_reg   <= right_next;
      key_reg     <= key_next;
      rc_reg      <= rc_next;
    end
  end

  assign rc_addr       = rc_addr_reg;
  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.out_valid = (state_reg == S_OUT);
  assign bus.out_left  = left_reg;
  assign bus.out_right = right_reg;
endmodule

// File: tb/tb_mimc_feistel_cipher.sv
// Randomised scoreboard bench for mimc_feistel_cipher with a wide-arithmetic
// MiMC reference model and a registered constant ROM.
module tb_mimc_feistel_cipher;
  localparam int NB = 254;
  localparam int NR = 220;
  localparam int RW = 8;
  localparam logic [511:0] P =
    512'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [NB-1:0] PM1 = NB'(P - 512'd1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] rc_addr;
  logic [NB-1:0] rc_data = '0;
  logic [NB-1:0] rom [0:255];

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [2*NB-1:0] exp_q [$];
  logic [RW-1:0]   trace_q [$];

  mimc_feistel_cipher_if #(.N_BITS(NB), .RW(RW)) bus ();

  mimc_feistel_cipher #(
    .N_BITS(NB), .N_ROUNDS(NR), .RW(RW), .GALOIS_MULT_METHOD("peasant")
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rc_addr(rc_addr), .rc_data(rc_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rc_data <= rom[rc_addr];

  task automatic check(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [NB-1:0] rand_fe();
    logic [255:0] v;
    do begin
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      v[255:254] = 2'b00;
    end while ({256'b0, v} >= P);
    return v[NB-1:0];
  endfunction

  // Reference: straight field arithmetic on wide integers.
  function automatic logic [2*NB-1:0] model(input logic [NB-1:0] l, input logic [NB-1:0] r,
                                            input logic [NB-1:0] k, input int rounds);
    logic [511:0] lw, rw_, kw, t, t2, t4, t5, v;
    lw = {258'b0, l};
    rw_ = {258'b0, r};
    kw = {258'b0, k};
    for (int i = 0; i < rounds; i++) begin
      t  = (lw + kw + {258'b0, rom[i]}) % P;
      t2 = (t * t) % P;
      t4 = (t2 * t2) % P;
      t5 = (t4 * t) % P;
      v  = (rw_ + t5) % P;
      if (i == rounds - 1) begin
        rw_ = v;
      end else begin
        rw_ = lw;
        lw  = v;
      end
    end
    return {lw[NB-1:0], rw_[NB-1:0]};
  endfunction

  // Constant-address trace: one entry per distinct address seen while busy.
  always @(negedge clk) begin
    if (bus.busy && (trace_q.size() == 0 || trace_q[$] != rc_addr))
      trace_q.push_back(rc_addr);
  end

  // Monitor: output stability under backpressure and scoreboard comparison.
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [NB-1:0] prev_l = '0;
  logic [NB-1:0] prev_rt = '0;
  always @(negedge clk) begin
    logic [2*NB-1:0] e;
    if (prev_v && !prev_r) begin
      check("hold_valid", NB'(bus.out_valid), NB'(1));
      check("hold_left", bus.out_left, prev_l);
      check("hold_right", bus.out_right, prev_rt);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got left=%h right=%h, want no result", bus.out_left, bus.out_right);
      end else begin
        e = exp_q.pop_front();
        check("result_left", bus.out_left, e[2*NB-1:NB]);
        check("result_right", bus.out_right, e[NB-1:0]);
        $display("result %0d: left=%h right=%h", n_out, bus.out_left, bus.out_right);
        n_out++;
      end
    end
    prev_v  = bus.out_valid;
    prev_r  = bus.out_ready;
    prev_l  = bus.out_left;
    prev_rt = bus.out_right;
  end

  // Offer a job, wait for acceptance, then scramble the inputs and keep
  // in_valid high for a few cycles while the engine is busy.
  task automatic start_job(input logic [NB-1:0] l, input logic [NB-1:0] r,
                           input logic [NB-1:0] k, input logic [RW-1:0] cfg);
    int guard;
    bus.in_left = l;
    bus.in_right = r;
    bus.key = k;
    bus.cfg_rounds = cfg;
    bus.in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, want 1", guard);
      finish_sim();
    end
    @(posedge clk);
    #1;
    trace_q.delete();
    check("busy_rise", NB'(bus.busy), NB'(1));
    check("in_ready_drop", NB'(bus.in_ready), NB'(0));
    repeat (3) begin
      bus.in_left = rand_fe();
      bus.in_right = rand_fe();
      bus.key = rand_fe();
      bus.cfg_rounds = RW'($urandom_range(1, 3));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // hold < 0: out_ready already high; otherwise hold it low for that many cycles.
  task automatic run_job(input logic [NB-1:0] l, input logic [NB-1:0] r, input logic [NB-1:0] k,
                         input logic [RW-1:0] cfg, input int rounds, input int hold,
                         input logic [2*NB-1:0] expv);
    int guard;
    exp_q.push_back(expv);
    bus.out_ready = (hold < 0);
    start_job(l, r, k, cfg);
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got out_valid=0 after %0d cycles, want 1", guard);
      finish_sim();
    end
    if (hold < 0) begin
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("single_cycle_consume", NB'(bus.out_valid), NB'(0));
      check("in_ready_return", NB'(bus.in_ready), NB'(1));
    end else begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
    check("fetch_count", NB'(trace_q.size()), NB'(rounds));
    for (int i = 0; i < trace_q.size() && i < rounds; i++)
      check("fetch_addr", NB'(trace_q[i]), NB'(i));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NB-1:0] l, r, k;
    int n, hold, guard;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    bus.in_valid = 1'b0;
    bus.in_left = '0;
    bus.in_right = '0;
    bus.key = '0;
    bus.cfg_rounds = '0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", NB'(bus.in_ready), NB'(1));
    check("reset_busy", NB'(bus.busy), NB'(0));
    check("reset_out_valid", NB'(bus.out_valid), NB'(0));
    check("reset_out_left", bus.out_left, '0);
    check("reset_out_right", bus.out_right, '0);
    check("reset_rc_addr", NB'(rc_addr), '0);
    @(posedge clk);
    #1;

    run_job(254'd1, 254'd0, 254'd0, RW'(1), 1, 0, {254'd1, 254'd1});
    run_job(254'd1, 254'd0, 254'd0, RW'(2), 2, -1, {254'd1, 254'd2});
    run_job(PM1, 254'd5, 254'd1, RW'(1), 1, 3, {PM1, 254'd5});

    for (int i = 0; i < NR; i++) rom[i] = rand_fe();
    for (int j = 0; j < 6; j++) begin
      l = rand_fe();
      r = rand_fe();
      k = rand_fe();
      n = int'($urandom_range(1, 6));
      hold = int'($urandom_range(0, 5)) - 1;
      run_job(l, r, k, RW'(n), n, hold, model(l, r, k, n));
    end

    l = rand_fe();
    r = rand_fe();
    k = rand_fe();
    run_job(l, r, k, RW'(0), NR, 10, model(l, r, k, NR));

    // Abort a full-length job once it reaches round 50.
    start_job(rand_fe(), rand_fe(), rand_fe(), RW'(0));
    guard = 0;
    @(negedge clk);
    while (rc_addr != RW'(50) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_round", NB'(rc_addr), NB'(50));
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", NB'(bus.in_ready), NB'(1));
    check("abort_busy", NB'(bus.busy), NB'(0));
    check("abort_out_valid", NB'(bus.out_valid), NB'(0));
    check("abort_out_left", bus.out_left, '0);
    check("abort_out_right", bus.out_right, '0);
    check("abort_rc_addr", NB'(rc_addr), '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rom[0] = '0;
    run_job(254'd1, 254'd0, 254'd0, RW'(1), 1, 2, {254'd1, 254'd1});

    repeat (5) @(negedge clk);
    check("scoreboard_empty", NB'(exp_q.size()), '0);
    finish_sim();
  end
endmodule
